// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: redirect kinds,
// FSM states and the sequential instruction step.
package pc_pkg;

    localparam logic [1:0] REDIR_PCREL = 2'b00;
    localparam logic [1:0] REDIR_JALR  = 2'b01;
    localparam logic [1:0] REDIR_TRAP  = 2'b10;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } pc_state_e;

    localparam int unsigned INSN_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a saturating count; the oldest entry
// is overwritten once the stack is full.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    input  logic            flush,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);
    assign top    = mem[ptr_q];
    assign empty  = (count_q == '0);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (flush) begin
            count_d = '0;
        end else if (push && do_pop) begin
            // Pop-then-push collapses to overwriting the current top in place.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_q + PW'(1);
            ptr_d   = ptr_q + PW'(1);
            count_d = (count_q == CW'(RAS_DEPTH)) ? count_q : count_q + CW'(1);
        end else if (do_pop) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: owns the fetch address, resolves execute redirects
// and predicts returns from the RAS.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_kind,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            dec_call,
    input  logic [XLEN-1:0] dec_link,
    input  logic            dec_ret,
    output logic            misalign
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pred_q, pred_d;
    logic            misalign_q, misalign_d;

    logic            run;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            kind_ok;
    logic            redir_take;
    logic            pred_take;
    logic            ras_flush;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    assign run = (state_q == ST_RUN);
    assign sum = redirect_base + redirect_imm;

    always_comb begin
        target  = sum;
        kind_ok = 1'b1;
        case (redirect_kind)
            REDIR_PCREL: target = sum;
            REDIR_JALR:  target = {sum[XLEN-1:1], 1'b0};
            REDIR_TRAP:  target = trap_vec;
            default:     kind_ok = 1'b0;
        endcase
    end

    assign redir_take = run && redirect_valid && kind_ok;
    assign ras_flush  = redir_take && (redirect_kind == REDIR_TRAP);
    assign pred_take  = run && dec_ret && !ras_empty && !redir_take;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (run && dec_call),
        .pop       (run && dec_ret),
        .push_data (dec_link),
        .flush     (ras_flush),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        pred_d     = pred_q;
        misalign_d = 1'b0;
        if (redir_take) begin
            // The target is loaded as-is; execute raises any misalignment trap.
            pc_d       = target;
            pred_d     = 1'b0;
            misalign_d = target[1];
        end else if (pred_take) begin
            pc_d   = ras_top;
            pred_d = 1'b1;
        end else if (run && fetch_ready) begin
            pc_d   = pc_q + XLEN'(INSN_STEP);
            pred_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pred_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_valid = run;
    assign fetch_pc    = pc_q;
    assign fetch_pred  = pred_q;
    assign misalign    = misalign_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator, the successor to the core's fixed 32-bit program counter. It owns the architectural fetch PC and presents it to instruction fetch over a valid/ready handshake. It accepts resolved redirects from execute (pc-relative branch/JAL, JALR, trap), and predicts returns with a small circular return-address stack (RAS) fed by decode. It sits between execute/decode feedback and the fetch stage.

## Interface
Parameters:
- XLEN, 32, address width in bits (≥ 16).
- RESET_VEC, 0, PC value after reset (word aligned).
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_valid  out  1  fetch_pc is a valid request.
- fetch_ready  in  1  fetch accepts the request this cycle.
- fetch_pc  out  XLEN  current fetch address.
- fetch_pred  out  1  fetch_pc came from a RAS prediction.
- redirect_valid  in  1  execute redirect, single-cycle pulse.
- redirect_kind  in  2  00 pc-relative, 01 JALR, 10 trap, 11 reserved (ignored).
- redirect_base  in  XLEN  instruction PC for kind 00; rs1 for kind 01.
- redirect_imm  in  XLEN  sign-extended immediate.
- trap_vec  in  XLEN  trap target for kind 10.
- dec_call  in  1  decode saw a call; push dec_link.
- dec_link  in  XLEN  return address to push (call PC + 4).
- dec_ret  in  1  decode saw a return; pop and predict.
- misalign  out  1  one-cycle flag: the last accepted redirect target had bit 1 set.

## Operation
- FSM states: BOOT, RUN.
  - Reset → BOOT: fetch_pc = RESET_VEC, fetch_valid = 0, fetch_pred = 0, misalign = 0, RAS count = 0, RAS pointer = 0.
  - BOOT → RUN unconditionally on the first clock edge after rst_n rises.
  - In RUN, fetch_valid = 1 continuously.
- Target arithmetic is modulo 2^XLEN; there is no overflow detection.
  - Kind 00: redirect_base + redirect_imm.
  - Kind 01: (redirect_base + redirect_imm) with bit 0 cleared.
  - Kind 10: trap_vec.
- misalign pulses when the final target has bit 1 set. The target is still loaded unchanged; execute raises the exception.
- Next-PC priority in RUN, highest first:
  1. redirect_valid with a valid kind: load the redirect target, fetch_pred ← 0.
  2. dec_ret with RAS count > 0: load the RAS top, fetch_pred ← 1.
  3. fetch_valid && fetch_ready: fetch_pc + 4, fetch_pred ← 0.
  4. Otherwise hold fetch_pc and fetch_pred (stall).
- Redirects and predictions do not wait for fetch_ready; the held request is replaced.
- RAS is circular with a pointer and a count saturating at RAS_DEPTH.
  - Push: write dec_link at ptr+1, advance ptr, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten (wrap).
  - Pop: read entry at ptr, retreat ptr, count − 1.
  - Pop when empty: no prediction, no state change.
  - dec_call && dec_ret in the same cycle: pop-then-push. Predict from the old top, then replace the top with dec_link; count is unchanged (if empty, count becomes 1).
  - A kind-10 redirect flushes the RAS: count ← 0. Decode pushes and pops in that same cycle are discarded.
  - Kinds 00/01 leave RAS contents unchanged. RAS push/pop still apply in the same cycle, but prediction is overridden by the redirect.
- dec_call/dec_ret are ignored in BOOT.

## Timing
- Every input takes effect on the next rising edge. fetch_pc, fetch_pred and misalign are registered outputs.
- Redirect latency: pulse in cycle N → fetch_pc = target in cycle N+1.
- Prediction latency: dec_ret in cycle N → fetch_pc = RAS top in cycle N+1.
- Handshake: fetch_pc and fetch_pred are stable while fetch_valid && !fetch_ready, unless a redirect or prediction fires.
- An rst_n assertion mid-operation immediately (asynchronously) forces all reset values. No in-flight state survives.

## Structure
- Shared package pc_pkg holds:
  - redirect-kind constants REDIR_PCREL, REDIR_JALR, REDIR_TRAP;
  - the FSM state enum;
  - the instruction-step constant (4).
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH; ports push, pop, push_data, flush, top, empty) holds the circular buffer and count. pc_gen holds the FSM, target adders and next-PC mux.

## Test plan
- Reset and boot: with RESET_VEC=0x100, release rst_n → one cycle with fetch_valid=0, then fetch_pc = 0x100, 0x104, 0x108 with fetch_ready=1.
- Stall: hold fetch_ready=0 for 3 cycles at 0x104 → fetch_pc stays 0x104 and fetch_valid stays 1; after fetch_ready=1 → 0x108.
- Redirect kinds:
  - kind 00, base 0x200, imm 0xFFFFFFF0 → fetch_pc 0x1F0;
  - kind 01, base 0x301, imm 0x4 → 0x304;
  - kind 10 → trap_vec;
  - kind 01, base 0x302, imm 0 → fetch_pc 0x302 and misalign=1 for one cycle.
- RAS with RAS_DEPTH=4:
  - push 0x10, 0x20, 0x30, 0x40, 0x50, then issue 5 rets → predictions 0x50, 0x40, 0x30, 0x20 with fetch_pred=1;
  - the 5th ret gives no prediction (sequential PC, fetch_pred=0).
- Priority and flush:
  - redirect kind 00 together with dec_ret → redirect target wins, and the RAS still pops;
  - trap redirect → the following dec_ret does not predict.
- Async reset mid-run: assert rst_n=0 between clock edges at fetch_pc 0x1F0 → fetch_pc = RESET_VEC and fetch_valid=0 immediately, without waiting for a clock edge.
